// File: rtl/iod_delay_trainer_pkg.sv
// iod_train_pkg: shared FSM states, direction codes and datapath widths for the IOD delay trainer
package iod_train_pkg;
  localparam int TAP_W = 8;
  localparam int CNT_W = 8;
  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;
  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_CLEAR, ST_SETTLE, ST_SAMPLE, ST_DECIDE, ST_MOVE, ST_DONE, ST_FAIL
  } state_t;
endpackage

// File: rtl/iod_delay_trainer_if.sv
// iod_delay_trainer_if: trainer bus (start, eye flags, range error in; load/move/dir/clear pulses, busy/done/fail, tap_pos out)
interface iod_delay_trainer_if;
  import iod_train_pkg::*;
  logic start;
  logic eye_monitor_early;
  logic eye_monitor_late;
  logic delay_line_out_of_range;
  logic delay_line_load;
  logic delay_line_move;
  logic delay_line_direction;
  logic eye_monitor_clear_flags;
  logic busy;
  logic done;
  logic fail;
  logic [TAP_W-1:0] tap_pos;
  modport master (
    input  start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
    output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
    output busy, done, fail, tap_pos
  );
  modport slave (
    output start, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
    input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
    input  busy, done, fail, tap_pos
  );
endinterface

// File: rtl/iod_eye_window_counter.sv
// iod_eye_window_counter: settle then sample timer with early/late tallies (clear/start/flags in; settle_done, window_done, early_cnt, late_cnt out)
module iod_eye_window_counter
  import iod_train_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             early,
  input  logic             late,
  output logic             settle_done,
  output logic             window_done,
  output logic [CNT_W-1:0] early_cnt,
  output logic [CNT_W-1:0] late_cnt
);
  logic settling, sampling;
  logic [7:0] cyc;
  assign settle_done = settling && cyc == 8'(SETTLE_CYCLES - 1);
  assign window_done = sampling && cyc == 8'(SAMPLE_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      settling  <= 1'b0;
      sampling  <= 1'b0;
      cyc       <= '0;
      early_cnt <= '0;
      late_cnt  <= '0;
    end else begin
      early_cnt <= clear ? '0 : early_cnt + CNT_W'(sampling && early);
      late_cnt  <= clear ? '0 : late_cnt + CNT_W'(sampling && late);
      settling  <= start || (!clear && settling && !settle_done);
      sampling  <= !start && !clear && (settle_done || (sampling && !window_done));
      cyc       <= (start || clear || settle_done || window_done) ? '0 : cyc + 8'(settling || sampling);
    end
endmodule

// File: rtl/iod_delay_trainer.sv
// iod_delay_trainer: per-lane RX delay centring FSM (fab_clk, arst, bus.master: drives IOD load/move/dir/clear, reports busy/done/fail/tap_pos)
module iod_delay_trainer
  import iod_train_pkg::*;
#(
  parameter int INIT_TAP      = 1,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 32,
  parameter int THRESH        = 4,
  parameter int LOCK_WINDOWS  = 3,
  parameter int MAX_MOVES     = 200
) (
  input logic                 fab_clk,
  input logic                 arst,
  iod_delay_trainer_if.master bus
);
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
  localparam logic [CNT_W:0]   THR      = (CNT_W + 1)'(THRESH);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_WINDOWS);
  localparam logic [9:0]       MOVE_N   = 10'(MAX_MOVES);
  state_t state, nxt;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] early_cnt, late_cnt;
  logic [3:0] lock_cnt;
  logic [9:0] move_cnt;
  logic dir, oor_q, oor_any, early_hi, late_hi, lock_hit, move_hit, settle_done, window_done;
  iod_eye_window_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_win (
    .clk        (fab_clk),
    .rst        (arst),
    .clear      (state == ST_CLEAR),
    .start      (state == ST_CLEAR),
    .early      (bus.eye_monitor_early),
    .late       (bus.eye_monitor_late),
    .settle_done(settle_done),
    .window_done(window_done),
    .early_cnt  (early_cnt),
    .late_cnt   (late_cnt)
  );
  assign oor_any  = oor_q || bus.delay_line_out_of_range;
  assign early_hi = {1'b0, early_cnt} >= {1'b0, late_cnt} + THR;
  assign late_hi  = {1'b0, late_cnt} >= {1'b0, early_cnt} + THR;
  assign lock_hit = lock_cnt + 4'd1 == LOCK_N;
  assign move_hit = move_cnt + 10'd1 == MOVE_N;
  assign bus.delay_line_load         = state == ST_LOAD;
  assign bus.eye_monitor_clear_flags = state == ST_CLEAR;
  assign bus.delay_line_move         = state == ST_MOVE;
  assign bus.delay_line_direction    = dir;
  assign bus.busy                    = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign bus.done                    = state == ST_DONE;
  assign bus.fail                    = state == ST_FAIL;
  assign bus.tap_pos                 = tap;
  always_ff @(posedge fab_clk or posedge arst)
    if (arst) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: nxt = bus.start ? ST_LOAD : state;
      ST_LOAD:   nxt = ST_CLEAR;
      ST_CLEAR:  nxt = ST_SETTLE;
      ST_SETTLE: nxt = settle_done ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: nxt = window_done ? ST_DECIDE : ST_SAMPLE;
      ST_DECIDE: nxt = oor_any  ? ST_FAIL :
                       early_hi ? (tap == TAP_MAX ? ST_FAIL : ST_MOVE) :
                       late_hi  ? (tap == '0 ? ST_FAIL : ST_MOVE) :
                       lock_hit ? ST_DONE : ST_CLEAR;
      ST_MOVE:   nxt = move_hit ? ST_FAIL : ST_CLEAR;
      default:   nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge fab_clk or posedge arst)
    if (arst) begin
      tap      <= TAP_INIT;
      dir      <= 1'b0;
      oor_q    <= 1'b0;
      lock_cnt <= '0;
      move_cnt <= '0;
    end else begin
      oor_q <= (nxt == ST_LOAD) ? 1'b0 : oor_any && state != ST_IDLE;
      if (state == ST_LOAD) begin
        tap      <= TAP_INIT;
        lock_cnt <= '0;
        move_cnt <= '0;
      end
      if (state == ST_DECIDE) lock_cnt <= (early_hi || late_hi) ? '0 : lock_cnt + 4'd1;
      if (state == ST_DECIDE && nxt == ST_MOVE) dir <= early_hi ? DIR_INC : DIR_DEC;
      if (state == ST_MOVE) begin
        tap      <= dir ? tap + 1'b1 : tap - 1'b1;
        move_cnt <= move_cnt + 10'd1;
      end
    end
endmodule

// File: tb/tb_iod_delay_trainer.sv
// tb_iod_delay_trainer: randomized scoreboard bench with a window-level reference model of the delay trainer
module tb_iod_delay_trainer;
  localparam int INIT_TAP = 1, MAX_TAP = 127, SETTLE = 8, SAMPLE = 32, THRESH = 4, LOCK_WIN = 3, MAX_MOVES = 10;
  localparam int NC = 2400;
  localparam logic [4:0] M_LOAD = 5'b00001, M_CLEAR = 5'b00010, M_MOVE = 5'b00100, M_DONE = 5'b01000, M_FAIL = 5'b10000;
  typedef struct {
    int rel;
    logic [4:0] mask;
    logic dir;
    bit chk_tap;
    logic [7:0] tap;
  } ev_t;
  logic fab_clk = 1'b0;
  logic arst = 1'b1;
  iod_delay_trainer_if bus ();
  iod_delay_trainer #(
    .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP), .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE),
    .THRESH(THRESH), .LOCK_WINDOWS(LOCK_WIN), .MAX_MOVES(MAX_MOVES)
  ) dut (
    .fab_clk(fab_clk),
    .arst   (arst),
    .bus    (bus)
  );
  ev_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, start_cyc = 0, drain_req = 0, drain_ack = 0;
  bit mon_en = 0, prev_term = 0;
  bit e_arr[NC], l_arr[NC];
  int modes[64];
  bit oor_en = 0;
  int oor_p = 0, end_rel = 0;
  always #5 fab_clk = ~fab_clk;
  always @(posedge fab_clk) cyc <= cyc + 1;
  function automatic void push(int rel, logic [4:0] mask, logic dir, bit chk, int tap);
    ev_t e;
    e.rel = rel;
    e.mask = mask;
    e.dir = dir;
    e.chk_tap = chk;
    e.tap = 8'(tap);
    exp_q.push_back(e);
  endfunction
  // Walks the training windows at the cycle level implied by the phase lengths,
  // filling the flag streams and queuing every pulse/terminal event the DUT must show.
  function automatic void build();
    int tap = INIT_TAP, moves = 0, lock = 0, c = 2, w = 0, e, l, s0, d;
    bit fin = 0, up, eb, lb;
    logic [4:0] t_mask = M_FAIL;
    for (int i = 0; i < NC; i++) begin
      e_arr[i] = 1'($urandom_range(0, 1));
      l_arr[i] = 1'($urandom_range(0, 1));
    end
    e_arr[0] = 0;
    l_arr[0] = 0;
    push(1, M_LOAD, 0, 0, 0);
    while (!fin) begin
      push(c, M_CLEAR, 0, 1, tap);
      s0 = c + 1 + SETTLE;
      e = 0;
      l = 0;
      for (int k = 0; k < SAMPLE; k++) begin
        case (modes[w])
          0: begin eb = 0; lb = 0; end
          1: begin eb = 1; lb = 0; end
          2: begin eb = 0; lb = 1; end
          3: begin eb = 1'($urandom_range(0, 1)); lb = 1'($urandom_range(0, 1)); end
          4: begin eb = 1'($urandom_range(0, 1)); lb = eb; end
          default: begin eb = $urandom_range(0, 3) != 0; lb = $urandom_range(0, 3) == 0; end
        endcase
        e_arr[s0+k] = eb;
        l_arr[s0+k] = lb;
        e += int'(eb);
        l += int'(lb);
      end
      d = s0 + SAMPLE;
      if (oor_en && oor_p <= d) begin
        end_rel = d + 1;
        fin = 1;
      end else if (e >= l + THRESH || l >= e + THRESH) begin
        up = e >= l + THRESH;
        if (up ? tap == MAX_TAP : tap == 0) begin
          end_rel = d + 1;
          fin = 1;
        end else begin
          push(d + 1, M_MOVE, up, 1, tap);
          tap += up ? 1 : -1;
          moves++;
          lock = 0;
          if (moves == MAX_MOVES) begin
            end_rel = d + 2;
            fin = 1;
          end else c = d + 2;
        end
      end else begin
        lock++;
        if (lock == LOCK_WIN) begin
          end_rel = d + 1;
          t_mask = M_DONE;
          fin = 1;
        end else c = d + 1;
      end
      w++;
    end
    push(end_rel, t_mask, 0, 1, tap);
    if (oor_p >= end_rel) oor_en = 0;
  endfunction
  task automatic run(bit busy_pulse, int abort_at);
    int busy_k;
    build();
    busy_k = busy_pulse ? int'($urandom_range(2, end_rel - 1)) : -1;
    @(posedge fab_clk);
    #1;
    start_cyc = cyc;
    mon_en = 1;
    bus.start = 1;
    bus.eye_monitor_early = 0;
    bus.eye_monitor_late = 0;
    bus.delay_line_out_of_range = 0;
    for (int rel = 1; rel <= end_rel + 2; rel++) begin
      @(posedge fab_clk);
      #1;
      if (rel == abort_at) begin
        arst = 1;
        bus.start = 0;
        bus.eye_monitor_early = 0;
        bus.eye_monitor_late = 0;
        repeat (3) @(posedge fab_clk);
        #1;
        exp_q.delete();
        mon_en = 0;
        arst = 0;
        return;
      end
      bus.start = rel == busy_k;
      bus.eye_monitor_early = rel <= end_rel ? e_arr[rel] : 1'b0;
      bus.eye_monitor_late = rel <= end_rel ? l_arr[rel] : 1'b0;
      bus.delay_line_out_of_range = oor_en && rel == oor_p;
    end
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge fab_clk);
    drain_req++;
    @(negedge fab_clk);
    #1;
    mon_en = 0;
  endtask
  always @(negedge fab_clk) begin
    logic [4:0] m;
    ev_t e;
    bit ok, exp_busy;
    int rel;
    m = {bus.fail && !prev_term, bus.done && !prev_term, bus.delay_line_move,
         bus.eye_monitor_clear_flags, bus.delay_line_load};
    prev_term <= bus.done || bus.fail;
    rel = cyc - start_cyc;
    if (arst) begin
      tests++;
      if ({m[2:0], bus.busy, bus.done, bus.fail, bus.delay_line_direction} !== 7'd0 || bus.tap_pos !== 8'(INIT_TAP)) begin
        fails++;
        $display("FAIL reset_state: pulses=%b busy=%b done=%b fail=%b dir=%b tap=%0d, required all 0 and tap=%0d",
                 m[2:0], bus.busy, bus.done, bus.fail, bus.delay_line_direction, bus.tap_pos, INIT_TAP);
      end
    end else if (mon_en && m != 5'd0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: rel=%0d mask=%b tap=%0d, required no event", rel, m, bus.tap_pos);
      end else begin
        e = exp_q.pop_front();
        exp_busy = !(e.mask inside {M_DONE, M_FAIL});
        ok = rel == e.rel && m == e.mask && bus.busy === exp_busy && !(bus.done && bus.fail) &&
             (e.mask != M_MOVE || bus.delay_line_direction === e.dir) &&
             (!e.chk_tap || bus.tap_pos === e.tap);
        if (!ok) begin
          fails++;
          $display("FAIL event: got rel=%0d mask=%b busy=%b done=%b fail=%b dir=%b tap=%0d, required rel=%0d mask=%b busy=%b dir=%b tap=%0d",
                   rel, m, bus.busy, bus.done, bus.fail, bus.delay_line_direction, bus.tap_pos,
                   e.rel, e.mask, exp_busy, e.dir, e.tap);
        end
      end
    end
    if (drain_req != drain_ack) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_event: %0d events outstanding (next rel=%0d mask=%b), required 0",
                 exp_q.size(), exp_q[0].rel, exp_q[0].mask);
      end
      drain_ack <= drain_req;
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0;
    bus.eye_monitor_early = 0;
    bus.eye_monitor_late = 0;
    bus.delay_line_out_of_range = 0;
    repeat (3) @(posedge fab_clk);
    #1;
    arst = 0;
    foreach (modes[i]) modes[i] = 0;
    run(1, 0);
    foreach (modes[i]) modes[i] = i < 5 ? 1 : 0;
    run(1, 0);
    foreach (modes[i]) modes[i] = 2;
    run(1, 0);
    foreach (modes[i]) modes[i] = 0;
    oor_en = 1;
    oor_p = 25;
    run(1, 0);
    oor_en = 0;
    foreach (modes[i]) modes[i] = 1;
    run(1, 0);
    foreach (modes[i]) modes[i] = 0;
    run(0, 25);
    run(1, 0);
    repeat (14) begin
      foreach (modes[i]) modes[i] = int'($urandom_range(0, 5));
      oor_en = $urandom_range(0, 3) == 0;
      oor_p = int'($urandom_range(1, 600));
      run(1, 0);
    end
    repeat (3) @(posedge fab_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iod_delay_trainer.md
Name: iod_delay_trainer

Overview:
- Per-lane receive-delay training sequencer for one IOD bit in the LPDDR3 PHY block.
- Drives the IOD dynamic delay-line controls (LOAD, MOVE, DIRECTION) and the eye-monitor clear.
- Uses the eye-monitor EARLY/LATE flags to step the delay tap until the sampling point is centred.
- Sits in the fabric clock domain beside each IOD instance. Reports done/fail and the current tap to the PHY training FSM.

Parameters:
- INIT_TAP, 1, tap value the IOD reloads on DELAY_LINE_LOAD; must match the IOD's static RX delay setting.
- MAX_TAP, 127, highest legal tap index.
- SETTLE_CYCLES, 8, wait after a flag clear or move before sampling starts (1..255).
- SAMPLE_CYCLES, 32, length of the observation window in cycles (1..255).
- THRESH, 4, minimum early/late count difference that triggers a move.
- LOCK_WINDOWS, 3, consecutive balanced windows required to declare lock (1..15).
- MAX_MOVES, 200, move budget before training is declared failed (1..1023).

Ports:
- FAB_CLK in 1: fabric clock; all logic is on the rising edge.
- ARST in 1: asynchronous, active-high reset.
- START in 1: one-cycle pulse that begins training; ignored while BUSY=1.
- EYE_MONITOR_EARLY in 1: IOD early flag, synchronous to FAB_CLK.
- EYE_MONITOR_LATE in 1: IOD late flag, synchronous to FAB_CLK.
- DELAY_LINE_OUT_OF_RANGE in 1: IOD delay-line range error.
- DELAY_LINE_LOAD out 1: one-cycle pulse that reloads the IOD tap to INIT_TAP.
- DELAY_LINE_MOVE out 1: one-cycle pulse that steps the IOD tap by 1.
- DELAY_LINE_DIRECTION out 1: 1 = increment, 0 = decrement; valid in the MOVE cycle.
- EYE_MONITOR_CLEAR_FLAGS out 1: one-cycle pulse that clears the IOD flags.
- BUSY out 1: training is in progress.
- DONE out 1: lock achieved; held until the next START.
- FAIL out 1: training failed; held until the next START.
- TAP_POS out 8: tracked IOD tap index.

Behaviour:
- Reset values (ARST=1, at any time, including mid-training):
  - FSM goes to IDLE.
  - All pulse outputs, BUSY, DONE and FAIL are 0.
  - TAP_POS = INIT_TAP.
  - All counters are 0.
  - No partial pulse is ever emitted after ARST asserts.
- State sequence: IDLE -> LOAD -> CLEAR -> SETTLE -> SAMPLE -> DECIDE -> (MOVE -> CLEAR | CLEAR | DONE | FAIL).
- IDLE:
  - START=1 -> LOAD.
  - On entry to LOAD: DONE and FAIL clear, BUSY sets, move_cnt and lock_cnt are zeroed.
- LOAD (1 cycle):
  - DELAY_LINE_LOAD=1 and TAP_POS<=INIT_TAP.
  - Next state is CLEAR.
- CLEAR (1 cycle):
  - EYE_MONITOR_CLEAR_FLAGS=1 and the early/late counters zero.
  - Next state is SETTLE.
- SETTLE:
  - Waits exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
  - Flags are ignored during SETTLE.
- SAMPLE (exactly SAMPLE_CYCLES cycles):
  - early_cnt increments in each cycle EYE_MONITOR_EARLY=1; late_cnt likewise for LATE.
  - Both flags high in the same cycle increments both.
  - Counter width is 8 bits, so no overflow for legal parameters.
- DECIDE (1 cycle, evaluated in priority order):
  1. DELAY_LINE_OUT_OF_RANGE=1 (sampled in any state other than IDLE) -> FAIL.
  2. early_cnt >= late_cnt + THRESH:
     - If TAP_POS == MAX_TAP -> FAIL.
     - Otherwise dir=1, lock_cnt<=0, -> MOVE.
  3. late_cnt >= early_cnt + THRESH:
     - If TAP_POS == 0 -> FAIL.
     - Otherwise dir=0, lock_cnt<=0, -> MOVE.
  4. Otherwise (balanced window): lock_cnt increments.
     - lock_cnt reaching LOCK_WINDOWS -> DONE.
     - Otherwise -> CLEAR.
  - Compare with 9-bit arithmetic so the sum cannot wrap.
- MOVE (1 cycle):
  - DELAY_LINE_MOVE=1 and DELAY_LINE_DIRECTION=dir. DIRECTION holds dir in this cycle and holds its last value otherwise.
  - TAP_POS steps ±1 on the same edge.
  - move_cnt increments; move_cnt reaching MAX_MOVES -> FAIL, otherwise -> CLEAR.
- DONE and FAIL are terminal states:
  - BUSY=0, and the respective flag is held.
  - START re-enters LOAD.
  - DONE and FAIL are never both 1.
- Latency: START to the first DELAY_LINE_LOAD is 1 cycle.
- Minimum time to DONE = 2 + LOCK_WINDOWS*(1+SETTLE_CYCLES+SAMPLE_CYCLES+1) cycles.
- An OUT_OF_RANGE assertion during SETTLE or SAMPLE is latched and acted on at the next DECIDE.

Decomposition:
- Shared package iod_train_pkg holds:
  - the state enum;
  - the DIR_INC/DIR_DEC constants;
  - the tap width constant (8).
- One natural sub-module, iod_eye_window_counter, covers the SAMPLE/SETTLE timing and early/late accumulation:
  - inputs: clear, start, flags;
  - outputs: window_done, early_cnt, late_cnt.
- The FSM and tap tracking stay in the top level.

Test Plan:
- Balanced eye (EARLY=LATE=0), defaults: START -> LOAD at cycle 1; DONE=1 after 2+3*42=128 cycles; TAP_POS=1; no MOVE pulses.
- EARLY=1 constant for the first 5 windows, then 0: exactly 5 MOVE pulses with DIRECTION=1; TAP_POS=6; then DONE after 3 further windows.
- LATE=1 constant, INIT_TAP=1: one MOVE with DIRECTION=0 (TAP_POS=0); the next DECIDE gives FAIL=1 with no further MOVE.
- DELAY_LINE_OUT_OF_RANGE pulsed for 1 cycle mid-SAMPLE: FAIL=1 at the following DECIDE; BUSY=0; DONE=0.
- EARLY=1 forever with MAX_MOVES=10, MAX_TAP=127: exactly 10 MOVE pulses, then FAIL; TAP_POS=11.
- ARST asserted during SAMPLE, then released, then START: all outputs are 0 with TAP_POS=INIT_TAP during reset; training restarts cleanly with a LOAD pulse. A START sent while BUSY=1 produces no second LOAD.
